// File: rtl/pio_in_pkg.sv
// Shared register map, address type and parameter sanity check for the edge-capture input PIO.
// Latency: none (package only).
// Backpressure: none (package only).
package pio_in_pkg;

   // 3-bit register select seen on the slave address bus
   typedef logic [2:0] reg_addr_t;

   localparam reg_addr_t ADDR_DATA  = 3'd0;  // filtered input, read-only
   localparam reg_addr_t ADDR_RISE  = 3'd1;  // rising-edge enable
   localparam reg_addr_t ADDR_MASK  = 3'd2;  // interrupt mask
   localparam reg_addr_t ADDR_EDGE  = 3'd3;  // edge capture, write-one-to-clear
   localparam reg_addr_t ADDR_FALL  = 3'd4;  // falling-edge enable
   localparam reg_addr_t ADDR_LEVEL = 3'd5;  // level-interrupt select
   localparam reg_addr_t ADDR_COUNT = 3'd6;  // saturating event counter, any write clears

   // Legal parameter envelope; checked once at elaboration by the top level
   function automatic bit params_ok(input int data_width, input int sync_stages,
                                    input int debounce_div, input int cnt_width);
      return (data_width  >= 1) && (data_width  <= 32) &&
             (sync_stages >= 2) && (sync_stages <= 4)  &&
             (debounce_div >= 0) &&
             (cnt_width   >= 1) && (cnt_width   <= 32);
   endfunction

endpackage

// File: rtl/pio_in_filter.sv
// Input conditioning: SYNC_STAGES-deep synchroniser, then optional tick-sampled two-sample debounce.
// Latency: SYNC_STAGES cycles to o_filt when bypassed; with debounce, a level must agree on two consecutive ticks.
// Backpressure: none; free-running per-cycle pipeline.
module pio_in_filter #(
   parameter int DATA_WIDTH   = 32,
   parameter int SYNC_STAGES  = 2,
   parameter int DEBOUNCE_DIV = 0
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic [DATA_WIDTH-1:0] i_in,
   output logic [DATA_WIDTH-1:0] o_filt
);

   logic [DATA_WIDTH-1:0] r_sync [SYNC_STAGES];
   logic [DATA_WIDTH-1:0] w_s;

   // Synchroniser chain: stage 0 takes the raw asynchronous pins
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            r_sync[k] <= '0;
         end
      end else begin
         r_sync[0] <= i_in;
         for (int k = 1; k < SYNC_STAGES; k++) begin
            r_sync[k] <= r_sync[k-1];
         end
      end
   end

   assign w_s = r_sync[SYNC_STAGES-1];

   generate
      if (DEBOUNCE_DIV == 0) begin : g_bypass
         // No filtering: the synchronised value is the filtered value
         assign o_filt = w_s;
      end else begin : g_debounce
         localparam int TW = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;
         localparam logic [TW-1:0] TICK_LAST = TW'(DEBOUNCE_DIV - 1);

         logic [TW-1:0]         r_tick;
         logic                  w_tick;
         logic [DATA_WIDTH-1:0] r_smp;
         logic [DATA_WIDTH-1:0] r_filt;
         logic [DATA_WIDTH-1:0] w_agree;

         assign w_tick  = (r_tick == TICK_LAST);
         // A bit is accepted only when this tick's sample matches the previous tick's
         assign w_agree = ~(w_s ^ r_smp);

         // Tick counter wraps at DEBOUNCE_DIV-1 and pulses w_tick on the wrap cycle
         always_ff @(posedge i_clk) begin
            if (i_reset) begin
               r_tick <= '0;
            end else if (w_tick) begin
               r_tick <= '0;
            end else begin
               r_tick <= r_tick + TW'(1);
            end
         end

         // On each tick: take a new sample and move agreeing bits to the filtered output
         always_ff @(posedge i_clk) begin
            if (i_reset) begin
               r_smp  <= '0;
               r_filt <= '0;
            end else if (w_tick) begin
               r_smp  <= w_s;
               r_filt <= (w_s & w_agree) | (r_filt & ~w_agree);
            end
         end

         assign o_filt = r_filt;
      end
   endgenerate

endmodule

// File: rtl/pio_in_edge_irq.sv
// Edge-capture input PIO slave: per-bit rise/fall/level interrupt sources, W1C capture, saturating event count.
// Latency: readdata 1 cycle after address; capture SYNC_STAGES+1 cycles after a pin edge (bypassed filter), irq 1 cycle later.
// Backpressure: none; the slave accepts every access in the cycle it is presented.
module pio_in_edge_irq
   import pio_in_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int SYNC_STAGES  = 2,
   parameter int DEBOUNCE_DIV = 0,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [2:0]            address,
   input  logic                  chipselect,
   input  logic                  write_n,
   input  logic [31:0]           writedata,
   input  logic [DATA_WIDTH-1:0] in_port,
   output logic [31:0]           readdata,
   output logic                  irq
);

   generate
      if (!params_ok(DATA_WIDTH, SYNC_STAGES, DEBOUNCE_DIV, CNT_WIDTH)) begin : g_param_err
         $error("pio_in_edge_irq: parameter out of range");
      end
   endgenerate

   // Edges are ignored until the synchroniser has flushed its reset zeros,
   // so a pin already high at reset release is not seen as a rising edge
   localparam logic [2:0]           PRIME_LAST = 3'(SYNC_STAGES + 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

   logic [DATA_WIDTH-1:0] w_f;
   logic [DATA_WIDTH-1:0] r_prev;
   logic [DATA_WIDTH-1:0] w_rise;
   logic [DATA_WIDTH-1:0] w_fall;
   logic [DATA_WIDTH-1:0] w_det;
   logic [DATA_WIDTH-1:0] w_wr_dat;
   logic [DATA_WIDTH-1:0] w_w1c;
   logic [DATA_WIDTH-1:0] w_irq_src;
   logic [DATA_WIDTH-1:0] r_rise_en;
   logic [DATA_WIDTH-1:0] r_irq_mask;
   logic [DATA_WIDTH-1:0] r_edge_cap;
   logic [DATA_WIDTH-1:0] r_fall_en;
   logic [DATA_WIDTH-1:0] r_level_mode;
   logic [CNT_WIDTH-1:0]  r_event_cnt;
   logic [2:0]            r_prime;
   logic                  w_primed;
   logic                  w_wr;
   logic                  w_any_det;
   logic [31:0]           w_rd_mux;
   logic [31:0]           r_readdata;
   logic                  r_irq;

   pio_in_filter #(
      .DATA_WIDTH   (DATA_WIDTH),
      .SYNC_STAGES  (SYNC_STAGES),
      .DEBOUNCE_DIV (DEBOUNCE_DIV)
   ) u_filter (
      .i_clk   (clk),
      .i_reset (reset),
      .i_in    (in_port),
      .o_filt  (w_f)
   );

   assign w_wr     = chipselect & ~write_n;
   assign w_wr_dat = writedata[DATA_WIDTH-1:0];
   assign w_w1c    = (w_wr && (address == ADDR_EDGE)) ? w_wr_dat : '0;

   assign w_primed  = (r_prime == PRIME_LAST);
   assign w_rise    = w_f & ~r_prev;
   assign w_fall    = ~w_f & r_prev;
   assign w_det     = w_primed ? ((w_rise & r_rise_en) | (w_fall & r_fall_en)) : '0;
   assign w_any_det = |w_det;

   // Level-mode bits interrupt on the live filtered input; others on their capture bit
   assign w_irq_src = r_irq_mask & ((r_edge_cap & ~r_level_mode) | (w_f & r_level_mode));

   // Prime counter: counts up after reset and holds once edge detection is armed
   always_ff @(posedge clk) begin
      if (reset) begin
         r_prime <= '0;
      end else if (!w_primed) begin
         r_prime <= r_prime + 3'd1;
      end
   end

   // Previous filtered value for edge detection
   always_ff @(posedge clk) begin
      if (reset) begin
         r_prev <= '0;
      end else begin
         r_prev <= w_f;
      end
   end

   // Software-writable configuration registers; upper writedata bits are dropped
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rise_en    <= '0;
         r_irq_mask   <= '0;
         r_fall_en    <= '0;
         r_level_mode <= '0;
      end else if (w_wr) begin
         case (address)
            ADDR_RISE:  r_rise_en    <= w_wr_dat;
            ADDR_MASK:  r_irq_mask   <= w_wr_dat;
            ADDR_FALL:  r_fall_en    <= w_wr_dat;
            ADDR_LEVEL: r_level_mode <= w_wr_dat;
            default:    ;
         endcase
      end
   end

   // Edge capture: W1C clears first, then a same-cycle detection re-sets the bit
   always_ff @(posedge clk) begin
      if (reset) begin
         r_edge_cap <= '0;
      end else begin
         r_edge_cap <= (r_edge_cap & ~w_w1c) | w_det;
      end
   end

   // Event counter: one count per cycle with any detection, saturating; a write clears it
   always_ff @(posedge clk) begin
      if (reset) begin
         r_event_cnt <= '0;
      end else if (w_wr && (address == ADDR_COUNT)) begin
         r_event_cnt <= w_any_det ? CNT_WIDTH'(1) : '0;
      end else if (w_any_det && (r_event_cnt != CNT_MAX)) begin
         r_event_cnt <= r_event_cnt + CNT_WIDTH'(1);
      end
   end

   // Registered interrupt request
   always_ff @(posedge clk) begin
      if (reset) begin
         r_irq <= 1'b0;
      end else begin
         r_irq <= |w_irq_src;
      end
   end

   // Read mux; evaluated every cycle regardless of chipselect
   always_comb begin
      w_rd_mux = '0;
      case (address)
         ADDR_DATA:  w_rd_mux = 32'(w_f);
         ADDR_RISE:  w_rd_mux = 32'(r_rise_en);
         ADDR_MASK:  w_rd_mux = 32'(r_irq_mask);
         ADDR_EDGE:  w_rd_mux = 32'(r_edge_cap);
         ADDR_FALL:  w_rd_mux = 32'(r_fall_en);
         ADDR_LEVEL: w_rd_mux = 32'(r_level_mode);
         ADDR_COUNT: w_rd_mux = 32'(r_event_cnt);
         default:    w_rd_mux = '0;
      endcase
   end

   // Registered read data
   always_ff @(posedge clk) begin
      if (reset) begin
         r_readdata <= '0;
      end else begin
         r_readdata <= w_rd_mux;
      end
   end

   assign readdata = r_readdata;
   assign irq      = r_irq;

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Bench for pio_in_edge_irq: three instances (plain, debounced, 2-bit counter) share one bus and pin vector.
// A behavioural model tracks the two unfiltered instances every cycle; directed reads pin the model and the debounced instance.
// Inputs change just after the falling edge; outputs are sampled on the falling edge.
module tb_pio_in_edge_irq;

   localparam int S = 2;

   logic        clk;
   logic        reset;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [7:0]  in_port;
   logic [31:0] rd_a, rd_b, rd_c;
   logic        irq_a, irq_b, irq_c;

   int n_checks = 0;
   int n_fail   = 0;

   pio_in_edge_irq #(.DATA_WIDTH(8), .SYNC_STAGES(S), .DEBOUNCE_DIV(0), .CNT_WIDTH(16)) dut_a (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
      .writedata(writedata), .in_port(in_port), .readdata(rd_a), .irq(irq_a));

   pio_in_edge_irq #(.DATA_WIDTH(8), .SYNC_STAGES(S), .DEBOUNCE_DIV(4), .CNT_WIDTH(16)) dut_b (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
      .writedata(writedata), .in_port(in_port), .readdata(rd_b), .irq(irq_b));

   pio_in_edge_irq #(.DATA_WIDTH(8), .SYNC_STAGES(S), .DEBOUNCE_DIV(0), .CNT_WIDTH(2)) dut_c (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
      .writedata(writedata), .in_port(in_port), .readdata(rd_c), .irq(irq_c));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- behavioural model (unfiltered instances a and c) ----------------
   logic [7:0]  m_log [$];      // pin samples, newest first
   logic [7:0]  m_rise, m_fall, m_mask, m_lvl, m_cap, m_prev;
   int          m_cnt_a, m_cnt_c, m_since;
   logic [31:0] m_rd_a, m_rd_c;
   bit          m_irq, m_valid;
   logic [7:0]  mf, mdet, mwd;
   logic [31:0] mrda, mrdc;
   bit          mirq, mwr;

   always @(posedge clk) begin
      if (reset) begin
         m_log.delete();
         m_rise = 0; m_fall = 0; m_mask = 0; m_lvl = 0; m_cap = 0; m_prev = 0;
         m_cnt_a = 0; m_cnt_c = 0; m_since = 0;
         m_rd_a = 0; m_rd_c = 0; m_irq = 0; m_valid = 1;
      end else begin
         // filtered input = pin value as it was S clock edges ago
         mf = (m_log.size() >= S) ? m_log[S-1] : 8'h00;
         mdet = 8'h00;
         if (m_since >= S + 1) begin
            for (int i = 0; i < 8; i++) begin
               if (mf[i] && !m_prev[i] && m_rise[i]) mdet[i] = 1'b1;
               if (!mf[i] && m_prev[i] && m_fall[i]) mdet[i] = 1'b1;
            end
         end
         case (address)
            3'd0: begin mrda = {24'h0, mf};     mrdc = mrda; end
            3'd1: begin mrda = {24'h0, m_rise}; mrdc = mrda; end
            3'd2: begin mrda = {24'h0, m_mask}; mrdc = mrda; end
            3'd3: begin mrda = {24'h0, m_cap};  mrdc = mrda; end
            3'd4: begin mrda = {24'h0, m_fall}; mrdc = mrda; end
            3'd5: begin mrda = {24'h0, m_lvl};  mrdc = mrda; end
            3'd6: begin mrda = m_cnt_a;         mrdc = m_cnt_c; end
            default: begin mrda = 0;            mrdc = 0; end
         endcase
         mirq = 0;
         for (int i = 0; i < 8; i++) begin
            if (m_mask[i] && (m_lvl[i] ? mf[i] : m_cap[i])) mirq = 1;
         end
         mwr = chipselect && !write_n;
         mwd = writedata[7:0];
         if (mwr && address == 3'd3) m_cap = m_cap & ~mwd;
         m_cap = m_cap | mdet;
         if (mwr && address == 3'd6) begin
            m_cnt_a = (mdet != 0) ? 1 : 0;
            m_cnt_c = m_cnt_a;
         end else if (mdet != 0) begin
            m_cnt_a = (m_cnt_a + 1 > 65535) ? 65535 : m_cnt_a + 1;
            m_cnt_c = (m_cnt_c + 1 > 3) ? 3 : m_cnt_c + 1;
         end
         if (mwr) begin
            case (address)
               3'd1: m_rise = mwd;
               3'd2: m_mask = mwd;
               3'd4: m_fall = mwd;
               3'd5: m_lvl  = mwd;
               default: ;
            endcase
         end
         m_prev = mf;
         m_log.push_front(in_port);
         if (m_log.size() > 8) void'(m_log.pop_back());
         if (m_since < 1000) m_since++;
         m_rd_a = mrda; m_rd_c = mrdc; m_irq = mirq;
      end
   end

   // Per-cycle comparison of instances a and c against the model
   always @(negedge clk) begin
      if (m_valid) begin
         n_checks += 4;
         if (rd_a !== m_rd_a) begin
            n_fail++; $display("FAIL model_rd_a t=%0t actual=%h required=%h", $time, rd_a, m_rd_a);
         end
         if (rd_c !== m_rd_c) begin
            n_fail++; $display("FAIL model_rd_c t=%0t actual=%h required=%h", $time, rd_c, m_rd_c);
         end
         if (irq_a !== m_irq) begin
            n_fail++; $display("FAIL model_irq_a t=%0t actual=%b required=%b", $time, irq_a, m_irq);
         end
         if (irq_c !== m_irq) begin
            n_fail++; $display("FAIL model_irq_c t=%0t actual=%b required=%b", $time, irq_c, m_irq);
         end
      end
   end

   // ---------------- directed helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] va, output logic [31:0] vb,
                     output logic [31:0] vc);
      address = a;
      @(negedge clk);
      va = rd_a; vb = rd_b; vc = rd_c;
   endtask

   logic [31:0] va, vb, vc;

   initial begin
      reset = 1'b1; address = 3'd0; chipselect = 1'b0; write_n = 1'b1;
      writedata = 32'h0; in_port = 8'h00;
      wait_cyc(3);
      reset = 1'b0;
      chk("reset_readdata", rd_a, 32'h0);
      chk("reset_irq", {31'h0, irq_a}, 32'h0);

      // rising edge on bit 0: capture after S+1 edges, irq one edge later, then W1C
      bus_write(3'd1, 32'h01);
      bus_write(3'd2, 32'h01);
      wait_cyc(5);
      address = 3'd3; in_port = 8'h01;
      wait_cyc(3);
      chk("rise_cap_not_yet", rd_a, 32'h0);
      chk("rise_irq_not_yet", {31'h0, irq_a}, 32'h0);
      wait_cyc(1);
      chk("rise_cap_set", rd_a, 32'h01);
      chk("rise_irq_set", {31'h0, irq_a}, 32'h1);
      bus_write(3'd3, 32'h01);
      rd(3'd3, va, vb, vc);
      chk("w1c_cap_clear", va, 32'h0);
      chk("w1c_irq_clear", {31'h0, irq_a}, 32'h0);

      // falling edges on bit 1 with event counting
      bus_write(3'd4, 32'h02);
      bus_write(3'd1, 32'h00);
      bus_write(3'd6, 32'h0);
      in_port = 8'h02; wait_cyc(5);
      in_port = 8'h00; wait_cyc(5);
      rd(3'd3, va, vb, vc);
      chk("fall_cap", va, 32'h02);
      rd(3'd6, va, vb, vc);
      chk("fall_count_1", va, 32'd1);
      in_port = 8'h02; wait_cyc(5);
      in_port = 8'h00; wait_cyc(5);
      rd(3'd6, va, vb, vc);
      chk("fall_count_2", va, 32'd2);
      chk("fall_count_2_c", vc, 32'd2);
      rd(3'd7, va, vb, vc);
      chk("addr7_zero", va, 32'h0);

      // priming: all pins high through reset, rising edges enabled at once
      in_port = 8'hFF; reset = 1'b1;
      wait_cyc(3);
      reset = 1'b0;
      bus_write(3'd1, 32'hFF);
      wait_cyc(8);
      rd(3'd3, va, vb, vc);
      chk("prime_no_capture", va, 32'h0);
      rd(3'd6, va, vb, vc);
      chk("prime_no_count", va, 32'h0);

      // W1C and detection in the same cycle: detection wins
      in_port = 8'h00; wait_cyc(5);
      bus_write(3'd3, 32'hFF);
      in_port = 8'h01;
      wait_cyc(2);
      bus_write(3'd3, 32'h01);
      rd(3'd3, va, vb, vc);
      chk("w1c_collide_kept", va, 32'h01);
      bus_write(3'd3, 32'h01);
      rd(3'd3, va, vb, vc);
      chk("w1c_next_clears", va, 32'h0);

      // reset in the middle of a captured event
      in_port = 8'h00; wait_cyc(4);
      in_port = 8'h01; wait_cyc(5);
      address = 3'd3;
      reset = 1'b1; in_port = 8'h00;
      wait_cyc(2);
      reset = 1'b0;
      chk("midreset_readdata", rd_a, 32'h0);
      chk("midreset_irq", {31'h0, irq_a}, 32'h0);
      rd(3'd3, va, vb, vc);
      chk("midreset_cap", va, 32'h0);

      // debounce (instance b): 3-cycle glitch rejected, long level accepted
      bus_write(3'd1, 32'h01);
      wait_cyc(10);
      in_port = 8'h01; wait_cyc(3);
      in_port = 8'h00; wait_cyc(12);
      rd(3'd0, va, vb, vc);
      chk("deb_glitch_data", vb, 32'h0);
      rd(3'd3, va, vb, vc);
      chk("deb_glitch_cap", vb, 32'h0);
      in_port = 8'h01; wait_cyc(16);
      rd(3'd0, va, vb, vc);
      chk("deb_level_data", vb, 32'h01);
      rd(3'd3, va, vb, vc);
      chk("deb_level_cap", vb, 32'h01);

      // level-mode interrupt on bit 2, follows the pin without W1C
      bus_write(3'd1, 32'h00);
      bus_write(3'd5, 32'h04);
      bus_write(3'd2, 32'h04);
      in_port = 8'h05; wait_cyc(5);
      chk("level_irq_high", {31'h0, irq_a}, 32'h1);
      in_port = 8'h01; wait_cyc(5);
      chk("level_irq_low", {31'h0, irq_a}, 32'h0);

      // counter saturation: five edges, 2-bit counter stops at 3
      bus_write(3'd1, 32'h0000_0301);
      rd(3'd1, va, vb, vc);
      chk("wdata_upper_ignored", va, 32'h01);
      in_port = 8'h00; wait_cyc(4);
      bus_write(3'd6, 32'h0);
      for (int p = 0; p < 5; p++) begin
         in_port = 8'h01; wait_cyc(4);
         in_port = 8'h00; wait_cyc(4);
      end
      wait_cyc(3);
      rd(3'd6, va, vb, vc);
      chk("count_five_a", va, 32'd5);
      chk("count_sat_c", vc, 32'd3);

      wait_cyc(2);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
